// File: rtl/input_debounce_pkg.sv
// Shared types and sizing helpers for the input debounce block.
package input_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } chan_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // A single-cycle debounce still needs a one-bit counter to keep the port legal.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = clog2(cycles);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_debounce_channel.sv
// One debounced input bit: two-flop synchroniser, qualifying-tick counter,
// STABLE/COUNTING FSM, registered level and registered edge strobes.
module debounce_channel
    import input_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic val,
    output logic val_rise,
    output logic val_fall,
    output logic commit
);

    localparam int unsigned          CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit                   SINGLE = (DEBOUNCE_CYCLES == 1);

    logic             s1;
    logic             s2;
    chan_state_t      state;
    chan_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             val_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= RESET_BIT;
            s2       <= RESET_BIT;
            val      <= RESET_BIT;
            state    <= STABLE;
            cnt      <= '0;
            val_rise <= 1'b0;
            val_fall <= 1'b0;
        end else begin
            s1       <= btn;
            s2       <= s1;
            val      <= val_next;
            state    <= state_next;
            cnt      <= cnt_next;
            val_rise <= commit & s2;
            val_fall <= commit & ~s2;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        val_next   = val;
        commit     = 1'b0;
        case (state)
            STABLE: begin
                if (s2 != val) begin
                    if (tick && SINGLE) begin
                        commit = 1'b1;
                    end else begin
                        state_next = COUNTING;
                        cnt_next   = tick ? CNT_W'(1) : '0;
                    end
                end
            end
            COUNTING: begin
                if (s2 == val) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt == LAST) begin
                        commit = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
        if (commit) begin
            val_next   = s2;
            cnt_next   = '0;
            state_next = STABLE;
        end
    end

endmodule

// File: rtl/input_debounce.sv
// WIDTH independent debounce channels plus a registered "any edge" flag
// that lines up with the per-bit rise/fall strobes.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TICK,
    input  logic [WIDTH-1:0] BTN,
    output logic [WIDTH-1:0] VAL,
    output logic [WIDTH-1:0] VAL_RISE,
    output logic [WIDTH-1:0] VAL_FALL,
    output logic             CHANGED
);

    logic [WIDTH-1:0] commit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VAL[i])
        ) u_ch (
            .clk      (CLK),
            .rst      (RST),
            .tick     (TICK),
            .btn      (BTN[i]),
            .val      (VAL[i]),
            .val_rise (VAL_RISE[i]),
            .val_fall (VAL_FALL[i]),
            .commit   (commit[i])
        );
    end

    // Registered from the combinational commits so it is high in the same cycle as the strobes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            CHANGED <= 1'b0;
        end else begin
            CHANGED <= |commit;
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce (WIDTH=4, DEBOUNCE_CYCLES=4): directed scenarios
// plus randomized traffic against a run-length reference model.
module tb_input_debounce;

    localparam int unsigned DC = 4;

    logic       CLK  = 1'b0;
    logic       RST  = 1'b0;
    logic       TICK = 1'b1;
    logic [3:0] BTN  = 4'h0;
    logic [3:0] VAL;
    logic [3:0] VAL_RISE;
    logic [3:0] VAL_FALL;
    logic       CHANGED;

    int checks   = 0;
    int failures = 0;

    // Reference model: a delayed copy of BTN and a count of consecutive
    // ticks during which the delayed input disagrees with the level.
    logic [3:0] m_s1 = '0;
    logic [3:0] m_s2 = '0;
    logic [3:0] m_val = '0;
    logic [3:0] m_rise = '0;
    logic [3:0] m_fall = '0;
    logic       m_chg = 1'b0;
    int         m_run [4] = '{0, 0, 0, 0};

    input_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DC),
        .RESET_VAL       (4'h0)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .TICK     (TICK),
        .BTN      (BTN),
        .VAL      (VAL),
        .VAL_RISE (VAL_RISE),
        .VAL_FALL (VAL_FALL),
        .CHANGED  (CHANGED)
    );

    always #5 CLK = ~CLK;

    task automatic cycle(input logic [3:0] b, input logic t, input logic r);
        logic [3:0] nr;
        logic [3:0] nf;
        BTN  = b;
        TICK = t;
        RST  = r;
        @(posedge CLK);
        if (!r) begin
            m_s1 = '0; m_s2 = '0; m_val = '0;
            m_rise = '0; m_fall = '0; m_chg = 1'b0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            nr = '0;
            nf = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_val[i]) begin
                    if (t) m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= DC) begin
                        nr[i]    = m_s2[i];
                        nf[i]    = ~m_s2[i];
                        m_val[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rise = nr;
            m_fall = nf;
            m_chg  = |(nr | nf);
            m_s2   = m_s1;
            m_s1   = b;
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        cycle(4'h0, 1'b1, 1'b0);
        cycle(4'h0, 1'b1, 1'b0);
        cycle(4'h0, 1'b1, 1'b1);
        cycle(4'h0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            cycle(4'($urandom), 1'b1, 1'b0);
            checks++;
            if (VAL !== 4'h0 || VAL_RISE !== 4'h0 || VAL_FALL !== 4'h0 || CHANGED !== 1'b0) begin
                failures++;
                $display("FAIL reset: VAL=%h RISE=%h FALL=%h CHG=%b required 0/0/0/0",
                         VAL, VAL_RISE, VAL_FALL, CHANGED);
            end
        end
    endtask

    task automatic test_reset_exit();
        logic [3:0] ev;
        logic [3:0] er;
        cycle(4'hF, 1'b1, 1'b0);
        cycle(4'hF, 1'b1, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            cycle(4'hF, 1'b1, 1'b1);
            ev = (e >= 6) ? 4'hF : 4'h0;
            er = (e == 6) ? 4'hF : 4'h0;
            checks++;
            if (VAL !== ev || VAL_RISE !== er || VAL_FALL !== 4'h0 || CHANGED !== (e == 6)) begin
                failures++;
                $display("FAIL reset_exit edge %0d: VAL=%h RISE=%h FALL=%h CHG=%b required %h/%h/0/%b",
                         e, VAL, VAL_RISE, VAL_FALL, CHANGED, ev, er, (e == 6));
            end
        end
    endtask

    task automatic test_press();
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            cycle(4'h1, 1'b1, 1'b1);
            checks++;
            if (VAL !== ((e >= 6) ? 4'h1 : 4'h0) || VAL_RISE !== ((e == 6) ? 4'h1 : 4'h0) ||
                VAL_FALL !== 4'h0 || CHANGED !== (e == 6)) begin
                failures++;
                $display("FAIL press edge %0d: VAL=%h RISE=%h FALL=%h CHG=%b", e, VAL, VAL_RISE,
                         VAL_FALL, CHANGED);
            end
        end
    endtask

    task automatic test_release();
        for (int e = 1; e <= 8; e++) begin
            cycle(4'h0, 1'b1, 1'b1);
            checks++;
            if (VAL !== ((e >= 6) ? 4'h0 : 4'h1) || VAL_FALL !== ((e == 6) ? 4'h1 : 4'h0) ||
                VAL_RISE !== 4'h0 || CHANGED !== (e == 6)) begin
                failures++;
                $display("FAIL release edge %0d: VAL=%h RISE=%h FALL=%h CHG=%b", e, VAL, VAL_RISE,
                         VAL_FALL, CHANGED);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int e = 1; e <= 13; e++) begin
            cycle((e <= 3) ? 4'h4 : 4'h0, 1'b1, 1'b1);
            checks++;
            if (VAL !== 4'h0 || VAL_RISE !== 4'h0 || VAL_FALL !== 4'h0 || CHANGED !== 1'b0) begin
                failures++;
                $display("FAIL glitch edge %0d: VAL=%h RISE=%h FALL=%h CHG=%b required 0/0/0/0",
                         e, VAL, VAL_RISE, VAL_FALL, CHANGED);
            end
        end
        // A full-length press afterwards shows the counter restarted from zero.
        for (int e = 1; e <= 7; e++) begin
            cycle(4'h4, 1'b1, 1'b1);
            checks++;
            if (VAL !== ((e >= 6) ? 4'h4 : 4'h0) || VAL_RISE !== ((e == 6) ? 4'h4 : 4'h0)) begin
                failures++;
                $display("FAIL glitch_recover edge %0d: VAL=%h RISE=%h", e, VAL, VAL_RISE);
            end
        end
    endtask

    task automatic test_tick_gating();
        do_reset();
        // Mismatch is first seen at edge 3; ticks on edges 3,6,9,12 -> commit at 12.
        for (int e = 1; e <= 16; e++) begin
            cycle(4'h2, (e % 3) == 0, 1'b1);
            checks++;
            if (VAL !== ((e >= 12) ? 4'h2 : 4'h0) || VAL_RISE !== ((e == 12) ? 4'h2 : 4'h0)) begin
                failures++;
                $display("FAIL tick_gating edge %0d: VAL=%h RISE=%h required %h/%h", e, VAL,
                         VAL_RISE, (e >= 12) ? 4'h2 : 4'h0, (e == 12) ? 4'h2 : 4'h0);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 1; e <= 4; e++) cycle(4'h8, 1'b1, 1'b1);
        cycle(4'h8, 1'b1, 1'b0);
        checks++;
        if (VAL !== 4'h0 || CHANGED !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_hold: VAL=%h CHG=%b required 0/0", VAL, CHANGED);
        end
        for (int e = 1; e <= 8; e++) begin
            cycle(4'h8, 1'b1, 1'b1);
            checks++;
            if (VAL !== ((e >= 6) ? 4'h8 : 4'h0) || VAL_RISE !== ((e == 6) ? 4'h8 : 4'h0)) begin
                failures++;
                $display("FAIL reset_mid edge %0d: VAL=%h RISE=%h", e, VAL, VAL_RISE);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        b = 4'h0;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
            end
            cycle(b, $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
            checks++;
            if (VAL !== m_val) begin
                failures++;
                $display("FAIL random_val cycle %0d: VAL=%h required %h", n, VAL, m_val);
            end
            checks++;
            if (VAL_RISE !== m_rise || VAL_FALL !== m_fall) begin
                failures++;
                $display("FAIL random_edges cycle %0d: RISE=%h FALL=%h required %h/%h", n,
                         VAL_RISE, VAL_FALL, m_rise, m_fall);
            end
            checks++;
            if (CHANGED !== m_chg || (VAL_RISE & VAL_FALL) !== 4'h0) begin
                failures++;
                $display("FAIL random_changed cycle %0d: CHG=%b required %b (RISE&FALL=%h)", n,
                         CHANGED, m_chg, VAL_RISE & VAL_FALL);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_exit();
        test_press();
        test_release();
        test_glitch();
        test_tick_gating();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
